// File: rtl/spi_target_regfile.sv
// spi_target_regfile: SPI target (mode 3, 16-bit frames) in front of a
// 16-entry read/write register bank plus a read-only WHOAMI register.
//
// Ports:
//   clk, reset        - system clock, asynchronous active-high reset
//   SPC, CS, SDI      - SPI clock (idle high), active-low select, data in
//                       (all asynchronous, synchronized internally)
//   SDO               - SPI data out, 0 outside the read data phase
//   host_we/addr/wdata- local write port into the bank (SPI write wins on clash)
//   wr_valid/addr/data- one-cycle notification of each committed SPI write
//   busy              - high while a frame is being handled
module spi_target_regfile #(
  parameter logic [7:0] WHOAMI_VAL = 8'h33,
  parameter logic [6:0] BASE_ADDR  = 7'h20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       SPC,
  input  logic       CS,
  input  logic       SDI,
  output logic       SDO,
  input  logic       host_we,
  input  logic [3:0] host_addr,
  input  logic [7:0] host_wdata,
  output logic       wr_valid,
  output logic [6:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       busy
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CMD   = 3'd1;
  localparam logic [2:0] S_WDATA = 3'd2;
  localparam logic [2:0] S_RDATA = 3'd3;
  localparam logic [2:0] S_DRAIN = 3'd4;

  logic [2:0] state;
  logic [3:0] bit_cnt;
  logic [1:0] spc_s, cs_s, sdi_s;
  logic       spc_q, cs_q;
  logic [1:0] sync_ok;
  logic       armed;
  logic [6:0] shift_in;
  logic [6:0] addr_q;
  logic [7:0] rd_shift;
  logic [7:0] bank [16];

  logic       spc_rise, cs_rise, cs_fall;
  logic [7:0] shift_next;

  assign spc_rise   = spc_s[1] & ~spc_q;
  assign cs_rise    = cs_s[1] & ~cs_q;
  // A falling CS only counts once a genuine high level has been seen after
  // reset, so a CS held low across reset release never starts a frame.
  assign cs_fall    = armed & cs_q & ~cs_s[1];
  assign shift_next = {shift_in, sdi_s[1]};

  assign SDO  = (state == S_RDATA) ? rd_shift[7] : 1'b0;
  assign busy = (state != S_IDLE);

  function automatic logic in_bank(input logic [6:0] a);
    return ({1'b0, a} >= {1'b0, BASE_ADDR}) &&
           ({1'b0, a} < ({1'b0, BASE_ADDR} + 8'd16));
  endfunction

  function automatic logic [3:0] bank_idx(input logic [6:0] a);
    return a[3:0] - BASE_ADDR[3:0];
  endfunction

  function automatic logic [7:0] rd_lookup(input logic [6:0] a);
    if (a == 7'h0F)  return WHOAMI_VAL;
    else if (in_bank(a)) return bank[bank_idx(a)];
    else             return 8'h00;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      bit_cnt  <= '0;
      spc_s    <= '1;
      cs_s     <= '1;
      sdi_s    <= '0;
      spc_q    <= 1'b1;
      cs_q     <= 1'b1;
      sync_ok  <= '0;
      armed    <= 1'b0;
      shift_in <= '0;
      addr_q   <= '0;
      rd_shift <= '0;
      wr_valid <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      for (int unsigned i = 0; i < 16; i++) bank[i] <= '0;
    end else begin
      spc_s   <= {spc_s[0], SPC};
      cs_s    <= {cs_s[0], CS};
      sdi_s   <= {sdi_s[0], SDI};
      spc_q   <= spc_s[1];
      cs_q    <= cs_s[1];
      sync_ok <= {sync_ok[0], 1'b1};
      if (sync_ok[1] && cs_s[1]) armed <= 1'b1;

      wr_valid <= 1'b0;
      // Host write first so an SPI commit to the same entry overrides it.
      if (host_we) bank[host_addr] <= host_wdata;

      if (cs_rise) begin
        state   <= S_IDLE;
        bit_cnt <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            if (cs_fall) begin
              state   <= S_CMD;
              bit_cnt <= '0;
            end
          end
          S_CMD: begin
            if (spc_rise) begin
              shift_in <= shift_next[6:0];
              bit_cnt  <= bit_cnt + 4'd1;
              if (bit_cnt == 4'd7) begin
                addr_q <= shift_next[6:0];
                if (shift_next[7]) begin
                  state    <= S_RDATA;
                  rd_shift <= rd_lookup(shift_next[6:0]);
                end else begin
                  state <= S_WDATA;
                end
              end
            end
          end
          S_WDATA: begin
            if (spc_rise) begin
              shift_in <= shift_next[6:0];
              bit_cnt  <= bit_cnt + 4'd1;
              if (bit_cnt == 4'd15) begin
                state <= S_DRAIN;
                if (in_bank(addr_q) && addr_q != 7'h0F) begin
                  bank[bank_idx(addr_q)] <= shift_next;
                  wr_valid <= 1'b1;
                  wr_addr  <= addr_q;
                  wr_data  <= shift_next;
                end
              end
            end
          end
          S_RDATA: begin
            if (spc_rise) begin
              rd_shift <= {rd_shift[6:0], 1'b0};
              bit_cnt  <= bit_cnt + 4'd1;
              if (bit_cnt == 4'd15) state <= S_DRAIN;
            end
          end
          S_DRAIN: ;
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_target_regfile.sv
// tb_spi_target_regfile: directed bench for spi_target_regfile with
// WHOAMI_VAL = 8'hB3. An SPI initiator task drives full, truncated or
// reset-interrupted frames; a monitor counts wr_valid cycles.
module tb_spi_target_regfile;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       SPC = 1'b1, CS = 1'b1, SDI = 1'b0;
  logic       SDO;
  logic       host_we = 1'b0;
  logic [3:0] host_addr = '0;
  logic [7:0] host_wdata = '0;
  logic       wr_valid;
  logic [6:0] wr_addr;
  logic [7:0] wr_data;
  logic       busy;

  int n_chk = 0;
  int n_fail = 0;
  int n_wr = 0;
  logic [6:0] last_waddr = '0;
  logic [7:0] last_wdata = '0;
  logic [7:0] rd;
  logic       cmd_sdo;
  int         wr_before;

  spi_target_regfile #(.WHOAMI_VAL(8'hB3), .BASE_ADDR(7'h20)) dut (
    .clk(clk), .reset(reset), .SPC(SPC), .CS(CS), .SDI(SDI), .SDO(SDO),
    .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (wr_valid) begin
      n_wr++;
      last_waddr = wr_addr;
      last_wdata = wr_data;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", tag, got, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // nbits < 16 truncates the frame; keep_cs leaves CS low at the end.
  // host_poke issues a host write of 8'h5A to entry 3 after the 8th edge.
  task automatic spi_xfer(input logic rw, input logic [6:0] addr, input logic [7:0] wdata,
                          input int nbits, input bit keep_cs, input bit host_poke,
                          output logic [7:0] rdata);
    logic [15:0] f;
    f = {rw, addr, wdata};
    rdata = '0;
    cmd_sdo = 1'b0;
    CS = 1'b0;
    wait_clk(6);
    for (int i = 0; i < nbits; i++) begin
      SPC = 1'b0;
      SDI = f[15 - i];
      wait_clk(6);
      if (i >= 8) rdata[15 - i] = SDO;
      else cmd_sdo = cmd_sdo | SDO;
      SPC = 1'b1;
      wait_clk(6);
      if (i == 7 && host_poke) begin
        host_addr = 4'd3; host_wdata = 8'h5A; host_we = 1'b1;
        wait_clk(1);
        host_we = 1'b0;
      end
    end
    if (!keep_cs) begin
      wait_clk(6);
      CS = 1'b1;
      wait_clk(8);
    end
  endtask

  initial begin
    wait_clk(3);
    chk("rst_sdo", SDO, 0);
    chk("rst_busy", busy, 0);
    chk("rst_wr_valid", wr_valid, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_wr_data", wr_data, 0);
    reset = 1'b0;
    wait_clk(5);

    // Write 0x21 <= A5, then read it back
    wr_before = n_wr;
    spi_xfer(1'b0, 7'h21, 8'hA5, 16, 0, 0, rd);
    chk("w21_pulses", n_wr - wr_before, 1);
    chk("w21_addr", last_waddr, 7'h21);
    chk("w21_data", last_wdata, 8'hA5);
    chk("w21_busy", busy, 0);
    spi_xfer(1'b1, 7'h21, 8'h00, 16, 0, 0, rd);
    chk("r21", rd, 8'hA5);
    chk("r21_cmd_sdo", cmd_sdo, 0);
    chk("r21_sdo_idle", SDO, 0);

    // WHOAMI read, write attempt, re-read
    spi_xfer(1'b1, 7'h0F, 8'h00, 16, 0, 0, rd);
    chk("r0F", rd, 8'hB3);
    wr_before = n_wr;
    spi_xfer(1'b0, 7'h0F, 8'h12, 16, 0, 0, rd);
    chk("w0F_pulses", n_wr - wr_before, 0);
    spi_xfer(1'b1, 7'h0F, 8'h00, 16, 0, 0, rd);
    chk("r0F_again", rd, 8'hB3);

    // Unmapped address
    spi_xfer(1'b1, 7'h05, 8'h00, 16, 0, 0, rd);
    chk("r05", rd, 8'h00);
    wr_before = n_wr;
    spi_xfer(1'b0, 7'h05, 8'hFF, 16, 0, 0, rd);
    chk("w05_pulses", n_wr - wr_before, 0);

    // Top of the bank (0x2F) and just past it (0x30)
    wr_before = n_wr;
    spi_xfer(1'b0, 7'h2F, 8'hC3, 16, 0, 0, rd);
    chk("w2F_pulses", n_wr - wr_before, 1);
    spi_xfer(1'b1, 7'h2F, 8'h00, 16, 0, 0, rd);
    chk("r2F", rd, 8'hC3);
    wr_before = n_wr;
    spi_xfer(1'b0, 7'h30, 8'h99, 16, 0, 0, rd);
    chk("w30_pulses", n_wr - wr_before, 0);

    // Abort: write 0x22 <= 3C, then truncated write of FF after 12 bits
    spi_xfer(1'b0, 7'h22, 8'h3C, 16, 0, 0, rd);
    wr_before = n_wr;
    spi_xfer(1'b0, 7'h22, 8'hFF, 12, 0, 0, rd);
    chk("abort_pulses", n_wr - wr_before, 0);
    chk("abort_busy", busy, 0);
    chk("abort_sdo", SDO, 0);
    spi_xfer(1'b1, 7'h22, 8'h00, 16, 0, 0, rd);
    chk("abort_r22", rd, 8'h3C);

    // Snapshot isolation from a host write
    spi_xfer(1'b0, 7'h23, 8'h11, 16, 0, 0, rd);
    spi_xfer(1'b1, 7'h23, 8'h00, 16, 0, 1, rd);
    chk("snap_r23", rd, 8'h11);
    spi_xfer(1'b1, 7'h23, 8'h00, 16, 0, 0, rd);
    chk("host_r23", rd, 8'h5A);

    // Reset in the middle of a write to 0x20
    spi_xfer(1'b0, 7'h20, 8'h77, 16, 0, 0, rd);
    wr_before = n_wr;
    spi_xfer(1'b0, 7'h20, 8'h44, 10, 1, 0, rd);
    reset = 1'b1;
    wait_clk(3);
    reset = 1'b0;
    SPC = 1'b1;
    wait_clk(12);
    chk("rstmid_pulses", n_wr - wr_before, 0);
    chk("rstmid_busy_cs_low", busy, 0);
    chk("rstmid_sdo", SDO, 0);
    CS = 1'b1;
    wait_clk(8);
    spi_xfer(1'b1, 7'h20, 8'h00, 16, 0, 0, rd);
    chk("rstmid_r20", rd, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_target_regfile.md
SPI_TARGET_REGFILE -- requirements
Module: spi_target_regfile

Interface
REQ-001 SHALL have parameter WHOAMI_VAL, default 8'h33, the read-only value returned at address 7'h0F.
REQ-002 SHALL have parameter BASE_ADDR, default 7'h20, the first address of a 16-entry read/write register bank (BASE_ADDR..BASE_ADDR+15).
REQ-003 SHALL have port clk, input, 1, the single system clock; all logic on its rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-005 SHALL have ports SPC, CS and SDI, each input, 1: the SPI clock (idle high), the active-low chip select and the initiator-to-target data, all asynchronous to clk.
REQ-006 SHALL have port SDO, output, 1, target-to-initiator data.
REQ-007 SHALL have ports host_we (input, 1), host_addr (input, 4) and host_wdata (input, 8), a local bank write port.
REQ-008 SHALL have ports wr_valid (output, 1), wr_addr (output, 7) and wr_data (output, 8), a one-cycle notification of each committed SPI write.
REQ-009 SHALL have port busy, output, 1, high while a frame is in progress.

Function
REQ-010 SHALL pass SPC, CS and SDI through two-flop synchronizers and detect SPC rise/fall and CS edges on the synchronized values.
REQ-011 SHALL require SPC high and low phases of at least 4 clk cycles each; behaviour below this limit is undefined.
REQ-012 SHALL treat a frame as: CS low, then 16 SPC cycles, MSB first. Bit 0 is RW (1 = read), bits 1-7 are address[6:0] and bits 8-15 are data[7:0].
REQ-013 SHALL sample SDI on each synchronized SPC rising edge while CS is low.
REQ-014 SHALL implement states IDLE, CMD, WDATA, RDATA and DRAIN. CS falling: IDLE->CMD with the bit counter at 0. After the 8th rising edge: CMD->RDATA if RW=1, else CMD->WDATA. After the 16th rising edge: ->DRAIN. CS rising in any state: ->IDLE.
REQ-015 SHALL, on the 8th rising edge of a read, snapshot the addressed value into a shift register: bank entry, WHOAMI_VAL, or 8'h00 for unmapped addresses.
REQ-016 SHALL present read bit 7 on SDO within 3 clk of the 8th rising edge, and each next bit within 3 clk of the rising edge that samples the current bit, so every bit is stable across the initiator's next SPC rising edge.
REQ-017 SHALL drive SDO to 0 in IDLE, CMD, WDATA and DRAIN.
REQ-018 SHALL commit a write to the bank on the cycle after the 16th rising edge. wr_valid SHALL pulse for exactly 1 cycle with wr_addr/wr_data set, and this SHALL happen only when the address is inside the bank.
REQ-019 SHALL drop writes to 7'h0F and to unmapped addresses, with no wr_valid pulse.
REQ-020 SHALL ignore extra SPC edges in DRAIN until CS rises; there is no address auto-increment.
REQ-021 SHALL, when CS rises before the 16th rising edge, abort the frame: no bank update, no wr_valid pulse, SDO=0, return to IDLE.
REQ-022 SHALL apply host_we writes to the bank entry host_addr in the next cycle. When host_we and an SPI commit target the same entry in the same cycle, the SPI write SHALL win.
REQ-023 SHALL keep a read snapshot unaffected by host writes that occur after the snapshot.
REQ-024 SHALL hold busy high from the CS falling detection until the return to IDLE.

Reset
REQ-025 SHALL, while reset is asserted, force state IDLE, bit counter 0, synchronizers to CS=1/SPC=1/SDI=0, SDO=0, wr_valid=0, wr_addr=0, wr_data=0, busy=0, and all bank entries to 8'h00.
REQ-026 SHALL treat reset asserted mid-frame as an abort: no write committed. After release it SHALL wait for a fresh CS falling edge, even if CS is already low.

Verification
REQ-027 SHALL verify that a write frame RW=0, addr 7'h21, data 8'hA5 gives a single wr_valid pulse with wr_addr=7'h21 and wr_data=8'hA5, and a later read of 7'h21 returns 8'hA5 on SDO.
REQ-028 SHALL verify that a read frame at addr 7'h0F returns SDO bits 1,0,1,1,0,0,1,1 (8'hB3 with WHOAMI_VAL=8'hB3), and that a write to 7'h0F gives no wr_valid pulse and the read value is unchanged.
REQ-029 SHALL verify that a read of unmapped addr 7'h05 returns 8'h00, and a write to it gives no wr_valid pulse.
REQ-030 SHALL verify abort: a write to 7'h22 with CS raised after 12 bits leaves entry 2 at its old value, gives no wr_valid pulse, and returns busy to 0.
REQ-031 SHALL verify that host_we to entry 3 with 8'h5A, issued after the 8th SPC edge of a read of 7'h23 holding 8'h11, still returns 8'h11, and a following read returns 8'h5A.
REQ-032 SHALL verify that reset asserted after 10 bits of a write to 7'h20 gives no wr_valid pulse, and after release entry 0 is 8'h00 and SDO is 0.
